// File: rtl/val_sig_arb_to_receiver_if.sv
// Per-receiver arbitration bus: request/handshake observation in,
// mux selects and grant status out.
interface val_sig_arb_to_receiver_if #(
    parameter int NUM = 8
);
    localparam int IDX_W = $clog2(NUM);

    logic [NUM-1:0]   aw_req;
    logic             s_awready;
    logic             s_wvalid;
    logic             s_wready;
    logic             s_wlast;
    logic [NUM-1:0]   aw_grant;
    logic [NUM-1:0]   w_select;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;

    // Fabric side: drives requests and receiver handshakes, consumes selects.
    modport master (
        output aw_req, s_awready, s_wvalid, s_wready, s_wlast,
        input  aw_grant, w_select, grant_idx, busy
    );

    // Arbiter side.
    modport slave (
        input  aw_req, s_awready, s_wvalid, s_wready, s_wlast,
        output aw_grant, w_select, grant_idx, busy
    );
endinterface

// File: rtl/val_sig_arb_to_receiver.sv
// Round-robin arbiter granting one of NUM masters access to a single receiver.
// The AW and W phases of the granted transaction retire independently; the
// grant is released only once both have completed.
module val_sig_arb_to_receiver #(
    parameter int NUM = 8
) (
    input logic                      ACLK,
    input logic                      ARESETn,
    val_sig_arb_to_receiver_if.slave bus
);
    localparam int IDX_W = $clog2(NUM);

    typedef enum logic [1:0] {
        StIdle,
        StAddrData,
        StAddrOnly,
        StDataOnly
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [NUM-1:0]   aw_grant_r;
    logic [NUM-1:0]   w_select_r;
    logic [IDX_W-1:0] grant_idx_r;
    logic             busy_r;

    logic [IDX_W-1:0] pick;
    logic             pick_valid;
    logic [NUM-1:0]   pick_onehot;
    logic [IDX_W-1:0] ptr_next;
    logic             aw_hs;
    logic             w_last_hs;
    logic             done;

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        int k;
        logic [IDX_W-1:0] kidx;
        pick       = '0;
        pick_valid = 1'b0;
        k          = 0;
        kidx       = '0;
        for (int i = 0; i < NUM; i++) begin
            k    = (int'(rr_ptr) + i) % NUM;
            kidx = IDX_W'(k);
            if (!pick_valid && bus.aw_req[kidx]) begin
                pick       = kidx;
                pick_valid = 1'b1;
            end
        end
    end

    // Handshake events and completion of the owned transaction.
    always_comb begin
        pick_onehot = NUM'(1) << pick;
        ptr_next    = (owner == IDX_W'(NUM - 1)) ? '0 : owner + 1'b1;
        aw_hs       = bus.aw_req[owner] & bus.s_awready;
        w_last_hs   = bus.s_wvalid & bus.s_wready & bus.s_wlast;
        done        = ((state == StAddrData) && aw_hs && w_last_hs) ||
                      ((state == StAddrOnly) && aw_hs) ||
                      ((state == StDataOnly) && w_last_hs);
    end

    // Arbitration FSM with registered outputs; owner is frozen while busy.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= StIdle;
            owner       <= '0;
            rr_ptr      <= '0;
            aw_grant_r  <= '0;
            w_select_r  <= '0;
            grant_idx_r <= '0;
            busy_r      <= 1'b0;
        end else if (done) begin
            state       <= StIdle;
            rr_ptr      <= ptr_next;
            aw_grant_r  <= '0;
            w_select_r  <= '0;
            grant_idx_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        state       <= StAddrData;
                        owner       <= pick;
                        aw_grant_r  <= pick_onehot;
                        w_select_r  <= pick_onehot;
                        grant_idx_r <= pick;
                        busy_r      <= 1'b1;
                    end
                end
                StAddrData: begin
                    if (aw_hs) begin
                        state      <= StDataOnly;
                        aw_grant_r <= '0;
                    end else if (w_last_hs) begin
                        state      <= StAddrOnly;
                        w_select_r <= '0;
                    end
                end
                StAddrOnly: begin
                    state <= StAddrOnly;
                end
                StDataOnly: begin
                    state <= StDataOnly;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    assign bus.aw_grant  = aw_grant_r;
    assign bus.w_select  = w_select_r;
    assign bus.grant_idx = grant_idx_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_val_sig_arb_to_receiver.sv
// Scoreboard bench: a transaction-level model predicts the outputs after each
// clock edge; a separate monitor compares them on the falling edge.
module tb_val_sig_arb_to_receiver;
    localparam int NUM   = 4;
    localparam int IDX_W = 2;
    localparam int OW    = 2 * NUM + IDX_W + 1;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b1;

    val_sig_arb_to_receiver_if #(.NUM(NUM)) bus ();

    val_sig_arb_to_receiver #(.NUM(NUM)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus.slave)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [OW-1:0] exp_q[$];

    // Model: one outstanding transaction with two independently retiring phases.
    bit m_busy;
    bit m_addr_pending;
    bit m_data_pending;
    int m_owner;
    int m_ptr;

    function automatic logic [OW-1:0] model_out();
        logic [NUM-1:0] ag;
        logic [NUM-1:0] ws;
        logic [IDX_W-1:0] idx;
        ag  = (m_busy && m_addr_pending) ? (NUM'(1) << m_owner) : '0;
        ws  = (m_busy && m_data_pending) ? (NUM'(1) << m_owner) : '0;
        idx = m_busy ? IDX_W'(m_owner) : '0;
        return {ag, ws, idx, m_busy};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {bus.aw_grant, bus.w_select, bus.grant_idx, bus.busy};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got aw=%b w=%b idx=%0d busy=%b, expected aw=%b w=%b idx=%0d busy=%b",
                     name, $time, act[OW-1 -: NUM], act[OW-1-NUM -: NUM], act[IDX_W:1], act[0],
                     exp[OW-1 -: NUM], exp[OW-1-NUM -: NUM], exp[IDX_W:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_addr_pending = 0; m_data_pending = 0; m_owner = 0; m_ptr = 0;
    endtask

    task automatic model_edge();
        bit aw, w;
        if (!ARESETn) begin
            model_reset();
        end else if (!m_busy) begin
            for (int i = 0; i < NUM; i++) begin
                int k;
                k = (m_ptr + i) % NUM;
                if (!m_busy && bus.aw_req[k]) begin
                    m_busy = 1; m_owner = k; m_addr_pending = 1; m_data_pending = 1;
                end
            end
        end else begin
            aw = m_addr_pending && bus.aw_req[m_owner] && bus.s_awready;
            w  = m_data_pending && bus.s_wvalid && bus.s_wready && bus.s_wlast;
            if (aw) m_addr_pending = 0;
            if (w)  m_data_pending = 0;
            if (!m_addr_pending && !m_data_pending) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NUM;
            end
        end
    endtask

    // Apply inputs, take one clock edge, queue the predicted result.
    task automatic step(input logic [NUM-1:0] req, input logic awr, input logic wv,
                        input logic wr, input logic wl);
        bus.aw_req    = req;
        bus.s_awready = awr;
        bus.s_wvalid  = wv;
        bus.s_wready  = wr;
        bus.s_wlast   = wl;
        @(posedge ACLK);
        model_edge();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic expect_now(input string name, input logic [NUM-1:0] ag,
                              input logic [NUM-1:0] ws, input logic [IDX_W-1:0] idx,
                              input logic bsy);
        @(negedge ACLK);
        #1;
        check(name, dut_out(), {ag, ws, idx, bsy});
    endtask

    task automatic async_reset();
        ARESETn = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_out(), '0);
        step('0, 0, 0, 0, 0);
        step('0, 0, 0, 0, 0);
        ARESETn = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    initial begin
        logic [OW-1:0] e;
        forever begin
            @(negedge ACLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", dut_out(), e);
            end
        end
    end

    initial begin
        bus.aw_req = '0; bus.s_awready = 0; bus.s_wvalid = 0; bus.s_wready = 0; bus.s_wlast = 0;
        model_reset();
        #2;
        async_reset();

        step('0, 0, 0, 0, 0);
        expect_now("idle_after_release", '0, '0, '0, 0);

        // First grant from pointer 0 goes to master 1.
        step(4'b0110, 0, 0, 0, 0);
        expect_now("first_grant", 4'b0010, 4'b0010, 2'd1, 1);
        step(4'b0110, 1, 0, 0, 0);
        expect_now("aw_first_data_only", 4'b0000, 4'b0010, 2'd1, 1);
        step(4'b0000, 0, 1, 1, 0);
        expect_now("beat1_not_last", 4'b0000, 4'b0010, 2'd1, 1);
        step(4'b0000, 0, 1, 1, 0);
        step(4'b0000, 0, 1, 1, 1);
        expect_now("burst_done_idle", '0, '0, '0, 0);

        // Pointer now 2: master 2 wins over master 1.
        step(4'b0110, 0, 0, 0, 0);
        expect_now("rr_ptr_two", 4'b0100, 4'b0100, 2'd2, 1);
        step(4'b0100, 0, 1, 1, 1);
        expect_now("w_first_addr_only", 4'b0100, 4'b0000, 2'd2, 1);
        step(4'b0100, 0, 1, 1, 1);
        expect_now("addr_only_ignores_w", 4'b0100, 4'b0000, 2'd2, 1);
        step(4'b0100, 1, 0, 0, 0);
        expect_now("addr_only_done", '0, '0, '0, 0);

        // Both phases together retire straight to idle.
        step(4'b1000, 0, 0, 0, 0);
        expect_now("grant_three", 4'b1000, 4'b1000, 2'd3, 1);
        step(4'b1000, 1, 1, 1, 1);
        expect_now("joint_done", '0, '0, '0, 0);

        // All requesting, single-beat bursts: 0,1,2,3,0 with one idle gap.
        for (int k = 0; k < 5; k++) begin
            logic [NUM-1:0] oh;
            oh = NUM'(1) << (k % NUM);
            step(4'b1111, 1, 1, 1, 1);
            expect_now("rotate_grant", oh, oh, IDX_W'(k % NUM), 1);
            step(4'b1111, 1, 1, 1, 1);
            expect_now("rotate_gap", '0, '0, '0, 0);
        end

        // Reset in the middle of a data-only phase owned by master 3.
        step(4'b1000, 0, 0, 0, 0);
        expect_now("owner_three", 4'b1000, 4'b1000, 2'd3, 1);
        step(4'b1000, 1, 0, 0, 0);
        expect_now("data_only_three", 4'b0000, 4'b1000, 2'd3, 1);
        async_reset();
        step(4'b1001, 0, 0, 0, 0);
        expect_now("post_reset_master0", 4'b0001, 4'b0001, 2'd0, 1);
        step(4'b1001, 1, 1, 1, 1);

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step(NUM'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0));
            end
        end

        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/val_sig_arb_to_receiver.md
VAL_SIG_ARB_TO_RECEIVER -- requirements
Module: val_sig_arb_to_receiver

Interface
REQ-001 SHALL have parameter NUM, default 8, number of sending masters competing for this receiver (slave) port; NUM >= 2.
REQ-002 SHALL have derived localparam IDX_W = $clog2(NUM), width of the encoded grant index.
REQ-003 SHALL have port ACLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port aw_req  input  NUM  bit i = master i drives AWVALID and its address decodes to this receiver.
REQ-006 SHALL have port s_awready  input  1  AWREADY from the receiver.
REQ-007 SHALL have port s_wvalid  input  1  WVALID as delivered to the receiver after W-channel muxing.
REQ-008 SHALL have port s_wready  input  1  WREADY from the receiver.
REQ-009 SHALL have port s_wlast  input  1  WLAST as delivered to the receiver after W-channel muxing.
REQ-010 SHALL have port aw_grant  output  NUM  one-hot select for the AW-channel value mux toward the receiver.
REQ-011 SHALL have port w_select  output  NUM  one-hot select for the W-channel value mux toward the receiver.
REQ-012 SHALL have port grant_idx  output  IDX_W  binary index of the current owner.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, ADDR_DATA, ADDR_ONLY and DATA_ONLY.
REQ-015 SHALL, in IDLE with aw_req != 0, pick the first set bit searching upward from rr_ptr with wrap at NUM-1 to 0, store it as owner and go to ADDR_DATA on the next edge.
REQ-016 SHALL, in IDLE with aw_req == 0, stay in IDLE.
REQ-017 SHALL define aw_hs = aw_req[owner] & s_awready and w_last_hs = s_wvalid & s_wready & s_wlast.
REQ-018 SHALL, in ADDR_DATA, go to IDLE if aw_hs and w_last_hs hold in the same cycle.
REQ-019 SHALL, in ADDR_DATA, go to DATA_ONLY on aw_hs alone.
REQ-020 SHALL, in ADDR_DATA, go to ADDR_ONLY on w_last_hs alone.
REQ-021 SHALL, in ADDR_DATA with neither event, hold state.
REQ-022 SHALL, in ADDR_ONLY, go to IDLE on aw_hs and ignore W signals.
REQ-023 SHALL, in DATA_ONLY, go to IDLE on w_last_hs and ignore aw_req.
REQ-024 SHALL NOT count non-last W beats (s_wlast=0) as completion; any burst length is allowed.
REQ-025 SHALL drive aw_grant = one-hot(owner) in ADDR_DATA and ADDR_ONLY, and 0 otherwise.
REQ-026 SHALL drive w_select = one-hot(owner) in ADDR_DATA and DATA_ONLY, and 0 otherwise, so W may complete before AW without deadlock.
REQ-027 SHALL drive grant_idx = owner while busy, and 0 in IDLE.
REQ-028 SHALL derive all outputs from registers only, with no combinational path from any input.
REQ-029 SHALL, on each transition into IDLE, set rr_ptr = owner+1, wrapping NUM-1 to 0.
REQ-030 SHALL NOT change owner, or re-arbitrate, while busy, even if aw_req[owner] drops.
REQ-031 SHALL place a new grant at the earliest 2 edges after the completing handshake edge (one IDLE cycle minimum).
REQ-032 SHALL grant each of the NUM masters within NUM transactions when all request continuously (starvation-free).

Reset
REQ-033 SHALL, while ARESETn=0, immediately force state=IDLE, rr_ptr=0, owner=0, aw_grant=0, w_select=0, grant_idx=0 and busy=0, without waiting for a clock edge.
REQ-034 SHALL, on reset asserted mid-transaction, drop all grants at once; after release the first arbitration starts from master 0.
REQ-035 SHALL leave the block idle on the first edge after ARESETn rises if aw_req=0.

Verification (NUM=4)
REQ-036 SHALL cover this scenario: reset, then aw_req=4'b0110 -> next edge aw_grant=w_select=0010, grant_idx=1, busy=1.
REQ-037 SHALL cover this scenario: owner 1, s_awready=1 with aw_req[1]=1 -> aw_grant=0, w_select=0010 (DATA_ONLY); 3 beats with wlast on beat 3 -> IDLE after the beat-3 edge, rr_ptr=2.
REQ-038 SHALL cover this scenario: owner 2, W burst ending before AW (wlast handshake first) -> ADDR_ONLY, w_select=0, aw_grant=0100; then aw_hs -> IDLE.
REQ-039 SHALL cover this scenario: aw_hs and w_last_hs in the same ADDR_DATA cycle -> IDLE directly; ADDR_ONLY and DATA_ONLY never entered.
REQ-040 SHALL cover this scenario: aw_req=1111 held, single-beat bursts -> grants in order 0,1,2,3,0 with exactly one IDLE cycle between grants.
REQ-041 SHALL cover this scenario: ARESETn pulsed low mid-DATA_ONLY with owner 3 -> outputs 0 without waiting for a clock; after release aw_req=1001 grants master 0.
